// File: rtl/int_ctrl.sv
// Trap/interrupt sequencer: on ecall/ebreak/mret/interrupt it stalls the pipeline, writes
// mepc/mstatus/mcause one per cycle over the CSR port, then redirects fetch.
module int_ctrl #(
  parameter logic [31:0] INT_CAUSE = 32'h8000_0007
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        is_ecall_i,
  input  logic        is_ebreak_i,
  input  logic        is_mret_i,
  input  logic        int_req_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MSTATUS,
    W_MCAUSE,
    JUMP,
    M_MSTATUS,
    M_JUMP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    unique case (state_q)
      IDLE: begin
        if (inst_valid_i) begin
          if (is_ecall_i) begin
            state_d = W_MEPC;
            cause_d = CAUSE_ECALL;
            epc_d   = inst_addr_i;
          end else if (is_ebreak_i) begin
            state_d = W_MEPC;
            cause_d = CAUSE_EBREAK;
            epc_d   = inst_addr_i;
          end else if (is_mret_i) begin
            state_d = M_MSTATUS;
          end else if (int_req_i && mstatus_i[3]) begin
            state_d = W_MEPC;
            cause_d = INT_CAUSE;
            epc_d   = inst_addr_i;
          end
        end
      end
      W_MEPC:    state_d = W_MSTATUS;
      W_MSTATUS: state_d = W_MCAUSE;
      W_MCAUSE:  state_d = JUMP;
      JUMP:      state_d = IDLE;
      M_MSTATUS: state_d = M_JUMP;
      M_JUMP:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    hold_flag_o  = (state_q != IDLE);
    unique case (state_q)
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_q;
      end
      W_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        csr_we_o       = 1'b1;
        csr_waddr_o    = CSR_MSTATUS;
        csr_wdata_o    = mstatus_i;
        csr_wdata_o[7] = mstatus_i[3];
        csr_wdata_o[3] = 1'b0;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = mtvec_i;
      end
      M_MSTATUS: begin
        // MIE <= MPIE, MPIE <= 1
        csr_we_o       = 1'b1;
        csr_waddr_o    = CSR_MSTATUS;
        csr_wdata_o    = mstatus_i;
        csr_wdata_o[3] = mstatus_i[7];
        csr_wdata_o[7] = 1'b1;
      end
      M_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Randomized scoreboard bench for int_ctrl: a rule-level model queues expected CSR writes and
// redirects with their due cycle; a monitor compares every cycle.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        is_ecall_i, is_ebreak_i, is_mret_i, int_req_i;
  logic [31:0] mtvec_i, mepc_i, mstatus_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o, csr_wdata_o;
  logic        hold_flag_o, int_assert_o;
  logic [31:0] int_addr_o;

  int_ctrl #(.INT_CAUSE(32'h8000_0007)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .is_ecall_i(is_ecall_i), .is_ebreak_i(is_ebreak_i), .is_mret_i(is_mret_i),
    .int_req_i(int_req_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          jump;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (mon_en) begin
        checks++;
        if (csr_we_o || int_assert_o) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out cyc=%0d: we=%b waddr=%h wdata=%h assert=%b addr=%h, expected none",
                     cyc, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o);
          end else begin
            e = exp_q.pop_front();
            if (e.jump)
              ok = (int_assert_o === 1'b1) && (csr_we_o === 1'b0) && (int_addr_o === e.data) &&
                   (csr_waddr_o === 32'h0) && (csr_wdata_o === 32'h0);
            else
              ok = (csr_we_o === 1'b1) && (int_assert_o === 1'b0) && (csr_waddr_o === e.addr) &&
                   (csr_wdata_o === e.data) && (int_addr_o === 32'h0);
            ok = ok && (hold_flag_o === 1'b1) && (cyc == e.cyc);
            if (!ok) begin
              failures++;
              $display("FAIL txn cyc=%0d: we=%b waddr=%h wdata=%h assert=%b addr=%h hold=%b, expected jump=%b addr=%h data=%h at cyc=%0d",
                       cyc, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, hold_flag_o,
                       e.jump, e.addr, e.data, e.cyc);
            end
          end
        end else begin
          ok = (hold_flag_o === 1'b0) && (csr_waddr_o === 32'h0) && (csr_wdata_o === 32'h0) &&
               (int_addr_o === 32'h0);
          if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            ok = 1'b0;
            $display("FAIL missing_txn cyc=%0d: no output, expected jump=%b addr=%h data=%h",
                     cyc, e.jump, e.addr, e.data);
          end else if (!ok) begin
            $display("FAIL idle cyc=%0d: hold=%b waddr=%h wdata=%h addr=%h, expected all 0",
                     cyc, hold_flag_o, csr_waddr_o, csr_wdata_o, int_addr_o);
          end
          if (!ok) failures++;
        end
      end
    end
  endtask

  function automatic void push(input bit j, input logic [31:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.jump = j; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Drives one execute-stage slot; on an accepted event holds the slot empty for the sequence length.
  task automatic step(input bit v, input bit ec, input bit eb, input bit mr, input bit ir,
                      input logic [31:0] pc, input logic [31:0] tv,
                      input logic [31:0] ep, input logic [31:0] ms);
    int          len;
    int          base;
    logic [31:0] cause;
    bit          trap;
    @(negedge clk);
    inst_valid_i = v; is_ecall_i = ec; is_ebreak_i = eb; is_mret_i = mr; int_req_i = ir;
    inst_addr_i = pc; mtvec_i = tv; mepc_i = ep; mstatus_i = ms;
    base = cyc + 1;
    len  = 0;
    trap = 0;
    cause = 0;
    if (v) begin
      if (ec)                 begin trap = 1; cause = 11; end
      else if (eb)            begin trap = 1; cause = 3; end
      else if (mr)            len = 2;
      else if (ir && ms[3])   begin trap = 1; cause = 32'h8000_0007; end
    end
    if (trap) begin
      len = 4;
      push(0, 32'h341, pc, base);
      push(0, 32'h300, (ms & ~32'h88) | (((ms >> 3) & 1) << 7), base + 1);
      push(0, 32'h342, cause, base + 2);
      push(1, 0, tv, base + 3);
    end else if (len == 2) begin
      push(0, 32'h300, (ms & ~32'h8) | (((ms >> 7) & 1) << 3) | 32'h80, base);
      push(1, 0, ep, base + 1);
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      inst_valid_i = 1'b0;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    rst_n = 1'b0;
    inst_valid_i = 0; is_ecall_i = 0; is_ebreak_i = 0; is_mret_i = 0; int_req_i = 0;
    inst_addr_i = 0; mtvec_i = 0; mepc_i = 0; mstatus_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_we", {31'h0, csr_we_o}, 32'h0);
    chk("rst_hold", {31'h0, hold_flag_o}, 32'h0);
    chk("rst_assert", {31'h0, int_assert_o}, 32'h0);
    chk("rst_waddr", csr_waddr_o, 32'h0);
    chk("rst_wdata", csr_wdata_o, 32'h0);
    chk("rst_addr", int_addr_o, 32'h0);
    rst_n = 1'b1;

    // Reset pulsed in the middle of a trap sequence
    @(negedge clk);
    inst_valid_i = 1; is_ecall_i = 1; inst_addr_i = 32'h100; mtvec_i = 32'h200; mstatus_i = 32'h8;
    @(negedge clk);
    inst_valid_i = 0;
    @(posedge clk);
    #2;
    chk("mid_waddr", csr_waddr_o, 32'h300);
    chk("mid_wdata", csr_wdata_o, 32'h80);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", {31'h0, csr_we_o}, 32'h0);
    chk("arst_hold", {31'h0, hold_flag_o}, 32'h0);
    chk("arst_waddr", csr_waddr_o, 32'h0);
    chk("arst_wdata", csr_wdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    is_ecall_i = 0;
    mon_en = 1;

    step(1, 1, 0, 0, 0, 32'h100, 32'h200, 32'h0,   32'h8);  // ecall restarts at W_MEPC
    step(1, 0, 0, 0, 1, 32'h120, 32'h200, 32'h0,   32'h0);  // interrupt masked
    step(1, 0, 0, 0, 1, 32'h120, 32'h200, 32'h0,   32'h8);  // interrupt taken
    step(1, 0, 0, 1, 0, 32'h0,   32'h200, 32'h104, 32'h80); // mret
    step(1, 1, 0, 0, 1, 32'h130, 32'h200, 32'h0,   32'h8);  // ecall beats interrupt
    step(1, 0, 0, 1, 0, 32'h0,   32'h200, 32'h134, 32'h80);
    step(1, 0, 0, 0, 1, 32'h134, 32'h200, 32'h0,   32'h88); // back-to-back interrupt
    step(1, 0, 0, 1, 0, 32'h0,   32'h200, 32'h140, 32'h00);
    step(1, 0, 0, 0, 1, 32'h140, 32'h200, 32'h0,   32'h00); // MIE still off
    step(0, 1, 0, 0, 0, 32'h150, 32'h200, 32'h0,   32'h8);  // bubble ignored
    step(1, 0, 1, 0, 1, 32'h160, 32'h300, 32'h0,   32'h8);  // ebreak
    step(1, 0, 1, 1, 0, 32'h170, 32'h300, 32'h0,   32'h0);  // ebreak beats mret

    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
           $urandom, $urandom, $urandom, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
